// File: rtl/pes_piso_pkg.sv
// pes_piso_pkg: shared state encoding and frame-geometry helpers for the PISO transmitter
package pes_piso_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
   function automatic int frame_len(int width, bit parity);
      return width + (parity ? 1 : 0);
   endfunction
   // Counter must also hold FRAME_LEN itself (value left after a frame that ends in IDLE)
   function automatic int cnt_w(int width, bit parity);
      return $clog2(frame_len(width, parity) + 1);
   endfunction
endpackage

// File: rtl/pes_piso_if.sv
// pes_piso_if: valid/ready word port feeding the PISO transmitter
//  in_data  word to transmit (master -> slave)
//  in_valid in_data is valid (master -> slave)
//  in_ready slave can accept a word (slave -> master)
interface pes_piso_if #(parameter int WIDTH = 4) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pes_piso_hold.sv
// pes_piso_hold: one-entry valid/ready holding register in front of the shifter
//  clk, rst_n           clock, async active-low reset
//  in_data/in_valid     upstream word and its valid
//  in_ready             register empty; accepts on in_valid & in_ready
//  out_data, out_full   held word and occupancy
//  take                 consumer drains the register this edge (only while full)
module pes_piso_hold #(parameter int WIDTH = 4) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_full,
   input  logic             take
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   // ready depends only on the flop, so a word drained at edge k is refilled at k+1 at the earliest
   assign in_ready = !full_q;
   assign out_data = data_q;
   assign out_full = full_q;
   always_comb begin
      full_d = take ? 1'b0 : (full_q | in_valid);
      data_d = (in_valid & !full_q) ? in_data : data_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end
endmodule

// File: rtl/pes_piso_tx.sv
// pes_piso_tx: parallel-in/serial-out transmitter, one bit per clock, idle-low line
//  clk, rst_n  clock, async active-low reset
//  in_if       valid/ready word port (slave)
//  sout        serial bit, sout_valid high while a frame bit is on it
//  done        pulse on the last bit of a frame
//  busy        FSM not idle or a word is held
//  PES_PISO_PARITY_EN: appends an even-parity bit to each frame
module pes_piso_tx
   import pes_piso_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int GAP_CYCLES = 1,
   parameter int MSB_FIRST  = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   pes_piso_if.slave   in_if,
   output logic        sout,
   output logic        sout_valid,
   output logic        done,
   output logic        busy
);
`ifdef PES_PISO_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int FL = frame_len(WIDTH, PAR_EN);
   localparam int CW = cnt_w(WIDTH, PAR_EN);
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   state_e           st_q, st_d;
   logic [FL-1:0]    shreg_q, shreg_d, shifted, load_w;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             sout_q, sout_d, sout_valid_q, sout_valid_d, done_q, done_d;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full, take, last, gap_end;
   pes_piso_hold #(.WIDTH(WIDTH)) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_if.in_data),
      .in_valid (in_if.in_valid),
      .in_ready (in_if.in_ready),
      .out_data (hold_data),
      .out_full (hold_full),
      .take     (take)
   );
`ifdef PES_PISO_PARITY_EN
   // Parity sits at the end of the shift order in either direction
   assign load_w = (MSB_FIRST != 0) ? {hold_data, ^hold_data} : {^hold_data, hold_data};
`else
   assign load_w = hold_data;
`endif
   always_comb begin
      last    = cnt_q == CW'(FL - 1);
      gap_end = int'(gap_q) == GAP_CYCLES - 1;
      shifted = (MSB_FIRST != 0) ? shreg_q << 1 : shreg_q >> 1;
      // Load from IDLE, back-to-back on the last bit when no gap, or straight out of the gap
      take    = hold_full & (st_q == IDLE | (st_q == SHIFT & last & GAP_CYCLES == 0) |
                             (st_q == GAP & gap_end));
      st_d    = take ? SHIFT :
                st_q == SHIFT ? (last ? (GAP_CYCLES > 0 ? GAP : IDLE) : SHIFT) :
                st_q == GAP ? (gap_end ? IDLE : GAP) : IDLE;
      shreg_d = take ? load_w : st_q == SHIFT ? shifted : shreg_q;
      cnt_d   = take ? '0 : st_q == SHIFT ? cnt_q + 1'b1 : cnt_q;
      gap_d   = st_q == GAP ? gap_q + 1'b1 : '0;
      // Outputs are registered from next-state values so they change only on clock edges
      sout_valid_d = st_d == SHIFT;
      sout_d       = sout_valid_d & ((MSB_FIRST != 0) ? shreg_d[FL-1] : shreg_d[0]);
      done_d       = sout_valid_d & (cnt_d == CW'(FL - 1));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         gap_q        <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         st_q         <= st_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         done_q       <= done_d;
      end
   end
   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
   assign done       = done_q;
   assign busy       = (st_q != IDLE) | hold_full;
endmodule

// File: tb/tb_pes_piso_tx.sv
// tb_pes_piso_tx: directed checks of pes_piso_tx in three configurations plus a word scoreboard
module tb_pes_piso_tx;
`ifdef PES_PISO_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = 4 + PAR;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   pes_piso_if #(.WIDTH(4)) if_a ();
   pes_piso_if #(.WIDTH(4)) if_b ();
   pes_piso_if #(.WIDTH(4)) if_c ();
   logic so_a, sv_a, dn_a, bz_a;
   logic so_b, sv_b, dn_b, bz_b;
   logic so_c, sv_c, dn_c, bz_c;
   pes_piso_tx #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_if(if_a.slave),
      .sout(so_a), .sout_valid(sv_a), .done(dn_a), .busy(bz_a));
   pes_piso_tx #(.WIDTH(4), .GAP_CYCLES(0), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_if(if_b.slave),
      .sout(so_b), .sout_valid(sv_b), .done(dn_b), .busy(bz_b));
   pes_piso_tx #(.WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_if(if_c.slave),
      .sout(so_c), .sout_valid(sv_c), .done(dn_c), .busy(bz_c));
   int checks = 0;
   int errors = 0;
   logic [3:0] sipo_q;
   logic [3:0] sb_q[$];
   logic [4:0] rx, got_f, exp_f;
   logic [3:0] w;
   int ntx = 0;
   int nrx = 0;
   // LSB-first receiver model standing in for pes_sipo
   always @(posedge clk or negedge rst_n)
      if (!rst_n) sipo_q <= '0;
      else if (sv_a) sipo_q <= {so_a, sipo_q[3:1]};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic rx_step;
      if (sv_c) rx = {rx[3:0], so_c};
      if (dn_c) begin
         chk("sb_word_expected", 32'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            w = sb_q.pop_front();
            exp_f = PAR != 0 ? {w, ^w} : {1'b0, w};
            got_f = PAR != 0 ? rx : {1'b0, rx[3:0]};
            chk("sb_word", got_f, exp_f);
            nrx++;
         end
      end
   endtask
   initial begin
      logic [8:0] s_v, v_v, d_v;
      logic [4:0] e_v;
      if_a.in_valid = 0; if_a.in_data = 0;
      if_b.in_valid = 0; if_b.in_data = 0;
      if_c.in_valid = 0; if_c.in_data = 0;
      rx = '0;
      #12;
      chk("rst_sout", so_a, 0);
      chk("rst_sout_valid", sv_a, 0);
      chk("rst_done", dn_a, 0);
      chk("rst_busy", bz_a, 0);
      chk("rst_in_ready", if_a.in_ready, 1);
      chk("rst_busy_b", bz_b, 0);
      chk("rst_busy_c", bz_c, 0);
      tick; tick;
      rst_n = 1;
`ifndef PES_PISO_PARITY_EN
      // single word 1011, LSB first
      if_a.in_data = 4'b1011; if_a.in_valid = 1;
      tick;
      if_a.in_valid = 0;
      chk("t1_ready_full", if_a.in_ready, 0);
      chk("t1_busy", bz_a, 1);
      chk("t1_no_bit_yet", sv_a, 0);
      e_v = 5'b01011;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("t1_sout", so_a, e_v[i]);
         chk("t1_sout_valid", sv_a, 1);
         chk("t1_done", dn_a, i == 3);
         if (i == 0) chk("t1_ready_drained", if_a.in_ready, 1);
      end
      tick;
      chk("t1_sipo", sipo_q, 4'hB);
      chk("t1_gap_sv", sv_a, 0);
      chk("t1_gap_sout", so_a, 0);
      tick;
      chk("t1_idle_busy", bz_a, 0);
`endif
      // reset during bit 2 of 4'hF with a second word held
      if_a.in_data = 4'hF; if_a.in_valid = 1;
      tick;
      if_a.in_data = 4'h7;
      tick;
      tick;
      if_a.in_valid = 0;
      chk("t2_hold_full", if_a.in_ready, 0);
      tick;
      chk("t2_bit2", so_a, 1);
      chk("t2_bit2_valid", sv_a, 1);
      rst_n = 0;
      #1;
      chk("t2_rst_sout", so_a, 0);
      chk("t2_rst_sv", sv_a, 0);
      chk("t2_rst_ready", if_a.in_ready, 1);
      chk("t2_rst_done", dn_a, 0);
      tick; tick;
      rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("t2_line_low", so_a, 0);
         chk("t2_no_valid", sv_a, 0);
         chk("t2_no_done", dn_a, 0);
      end
      chk("t2_idle", bz_a, 0);
`ifndef PES_PISO_PARITY_EN
      // 4'hA then 4'h5 with in_valid held, one idle bit between frames
      s_v = 9'b0_1010_1010; v_v = 9'b1_1110_1111; d_v = 9'b1_0000_1000;
      if_a.in_data = 4'hA; if_a.in_valid = 1;
      tick;
      if_a.in_data = 4'h5;
      for (int i = 0; i < 9; i++) begin
         tick;
         chk("t3_sout", so_a, s_v[i]);
         chk("t3_sout_valid", sv_a, v_v[i]);
         chk("t3_done", dn_a, d_v[i]);
         if (i == 0) chk("t3_ready_empty", if_a.in_ready, 1);
         if (i == 1) begin
            chk("t3_ready_full", if_a.in_ready, 0);
            if_a.in_valid = 0;
         end
      end
      tick; tick;
      // back-to-back 4'h3, 4'hC without gap
      s_v = 9'b0_1100_0011; v_v = 9'b0_1111_1111; d_v = 9'b0_1000_1000;
      if_b.in_data = 4'h3; if_b.in_valid = 1;
      tick;
      if_b.in_data = 4'hC;
      for (int i = 0; i < 9; i++) begin
         tick;
         chk("t4_sout", so_b, s_v[i]);
         chk("t4_sout_valid", sv_b, v_v[i]);
         chk("t4_done", dn_b, d_v[i]);
         if (i == 1) if_b.in_valid = 0;
      end
`else
      // parity frames: 0111 -> 1,1,1,0,1 and 0000 -> all zero
      if_a.in_data = 4'b0111; if_a.in_valid = 1;
      tick;
      if_a.in_valid = 0;
      e_v = 5'b10111;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("t5_sout", so_a, e_v[i]);
         chk("t5_sout_valid", sv_a, 1);
         chk("t5_done", dn_a, i == 4);
      end
      tick; tick;
      if_a.in_data = 4'b0000; if_a.in_valid = 1;
      tick;
      if_a.in_valid = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("t5_zero_sout", so_a, 0);
         chk("t5_zero_valid", sv_a, 1);
         chk("t5_zero_done", dn_a, i == 4);
      end
`endif
      // MSB first: 1000 -> 1,0,0,0 (then parity 1 when enabled)
      e_v = PAR != 0 ? 5'b10001 : 5'b00001;
      if_c.in_data = 4'b1000; if_c.in_valid = 1;
      tick;
      if_c.in_valid = 0;
      for (int i = 0; i < FL; i++) begin
         tick;
         chk("t6_msb_sout", so_c, e_v[i]);
         chk("t6_msb_valid", sv_c, 1);
         chk("t6_msb_done", dn_c, i == FL - 1);
      end
      tick; tick;
      // random valid pulses: every accepted word comes out exactly once, in order
      for (int i = 0; i < 400; i++) begin
         if_c.in_valid = $urandom_range(0, 2) == 0;
         if_c.in_data = 4'($urandom_range(0, 15));
         if (if_c.in_valid && if_c.in_ready) begin
            sb_q.push_back(if_c.in_data);
            ntx++;
         end
         rx_step();
         tick;
      end
      if_c.in_valid = 0;
      for (int i = 0; i < 40; i++) begin
         rx_step();
         tick;
      end
      chk("sb_count", nrx, ntx);
      chk("sb_drained", sb_q.size(), 0);
      chk("sb_some_traffic", 32'(ntx > 10), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
